alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit ALU operation code from the ALU control decoder and produces the result.
- Simple ops (ADD/SUB/AND/OR/XOR/LUI) complete in 1 cycle.
- SLL/SRL run on an iterative 1-bit-per-cycle shifter.
- Valid/ready on both sides; busy_o feeds the pipeline hazard unit as an EX stall request.

Parameters:
DATA_WIDTH, 32, operand/result width
SHAMT_W, 5, shift-amount width, equal to log2(DATA_WIDTH)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
valid_i  in  1  operation request valid
ready_o  out  1  unit can accept an operation this cycle
ALU_Operation_i  in  4  op code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0110 SLL, 0111 SRL, 1001 LUI
A_i  in  DATA_WIDTH  operand A (rs1 / PC)
B_i  in  DATA_WIDTH  operand B (rs2 / immediate); B_i[SHAMT_W-1:0] is the shift amount
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
ALU_Result_o  out  DATA_WIDTH  registered result
Zero_o  out  1  registered, equals (ALU_Result_o == 0)
busy_o  out  1  high while state == SHIFT (stall request)

Behaviour:
- Reset (asynchronous, reset == 0):
  - state = IDLE; shifter count and accumulator cleared.
  - valid_o = 0, ALU_Result_o = 0, Zero_o = 0, busy_o = 0.
  - Any operation in flight is discarded; no result is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- Accept: an operation is taken on a rising edge when valid_i && ready_o.
  - ready_o = (state == IDLE) || (state == DONE && ready_i). Combinational path from ready_i to ready_o is allowed and intended.
  - When ready_o == 0, inputs are ignored and operands are not sampled.
- Non-shift op accepted: result is computed and registered on the accepting edge; state goes to DONE. valid_o is high 1 edge after accept.
- Arithmetic: modulo 2^DATA_WIDTH, carries discarded.
  - ADD = A+B; SUB = A-B (two's complement, wraps).
  - AND/OR/XOR are bitwise.
  - LUI: result = B_i unchanged (immediate arrives pre-shifted).
  - Undefined codes (0101, 1000, 1010-1111): result 0, Zero_o = 1, 1-cycle latency.
- Shift op accepted with n = B_i[SHAMT_W-1:0]:
  - Accumulator loads A_i; count loads n.
  - n == 0: state goes directly to DONE with result = A_i.
  - n > 0: state goes to SHIFT. Each edge in SHIFT shifts the accumulator 1 bit (SLL: left, fill 0; SRL: right, fill 0) and decrements the count. The edge on which count reaches 0 moves state to DONE.
  - Total latency is n+1 edges including the accept edge.
  - Upper bits of B_i are ignored.
- DONE:
  - valid_o = 1; ALU_Result_o and Zero_o are held stable until ready_i.
  - ready_i && !valid_i: go to IDLE, valid_o = 0.
  - ready_i && valid_i: the new op is accepted on the same edge (back-to-back, one result per cycle for simple ops).
- SHIFT: busy_o = 1, ready_o = 0, valid_o = 0; ready_i is ignored.

Optional Feature:
ALU_FAST_SHIFT_EN:
- Defined: SLL/SRL use a barrel shifter and complete in 1 cycle like other ops. The SHIFT state is never entered and busy_o is tied 0.
- Undefined: iterative shifter exactly as described in Behaviour.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package alu_pkg holds:
  - op-code localparams (ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011, ALU_XOR=4'b0100, ALU_SLL=4'b0110, ALU_SRL=4'b0111, ALU_LUI=4'b1001);
  - FSM state encoding.
  The ALU control decoder uses the same constants.
- One sub-module, alu_iter_shifter, owns the accumulator, count, load/step/done signals, and the fast-shift macro branch.

Test Plan:
- Reset asserted mid-SHIFT (SLL, n=20, at cycle 5): outputs go to 0 asynchronously; after release ready_o=1, valid_o=0, and no stale result appears.
- ADD A=0xFFFFFFFF, B=1: result 0x00000000, Zero_o=1, valid_o high 1 edge after accept. SUB A=5, B=7: result 0xFFFFFFFE.
- SLL A=0x00000001, B=31: busy_o high for 31 cycles, then result 0x80000000 with valid_o after 32 edges. SRL A=0x80000000, B=0x00000024 (n=4): result 0x08000000.
- Back-to-back: XOR then OR with ready_i held 1 and valid_i held 1: one result per cycle; XOR 0xF0F0^0x0FF0=0xFF00, then OR result.
- Backpressure: ready_i=0 for 3 cycles in DONE with a LUI B=0x12345000: result held stable, ready_o=0, new valid_i ignored; released on ready_i=1.
- ALU_FAST_SHIFT_EN build: SLL A=3, B=4 gives 0x30 after 1 edge, busy_o never asserts. Undefined code 1111 gives result 0, Zero_o=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes and execute-unit FSM encoding.
// The ALU control decoder uses these same op-code constants.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Shifter for SLL/SRL: iterative 1 bit per cycle by default, or a single-cycle
// barrel shifter when ALU_FAST_SHIFT_EN is defined.
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_left,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [SHAMT_W-1:0]    i_shamt,
    output logic                  o_imm_valid,
    output logic [DATA_WIDTH-1:0] o_imm_result,
    output logic                  o_last,
    output logic [DATA_WIDTH-1:0] o_step_val
);

`ifdef ALU_FAST_SHIFT_EN
    assign o_imm_valid  = 1'b1;
    assign o_imm_result = i_left ? (i_a << i_shamt) : (i_a >> i_shamt);
    assign o_last       = 1'b0;
    assign o_step_val   = '0;
`else
    logic [DATA_WIDTH-1:0] r_acc;
    logic [SHAMT_W-1:0]    r_cnt;
    logic                  r_left;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_left <= 1'b0;
        end else if (i_load) begin
            r_acc  <= i_a;
            r_cnt  <= i_shamt;
            r_left <= i_left;
        end else if (i_step) begin
            r_acc  <= o_step_val;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end

    // A zero shift amount needs no iterations; the operand is the result.
    assign o_imm_valid  = (i_shamt == '0);
    assign o_imm_result = i_a;
    assign o_last       = (r_cnt == SHAMT_W'(1));
    assign o_step_val   = r_left ? (r_acc << 1) : (r_acc >> 1);
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; shifts go through alu_iter_shifter
// (single-cycle when ALU_FAST_SHIFT_EN is defined).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o,
    output logic                  busy_o
);

    function automatic logic [DATA_WIDTH-1:0] alu_compute(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_LUI: return b;
            default: return '0;
        endcase
    endfunction

    alu_state_t            r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_result, w_res_nxt;
    logic                  r_zero, w_res_en;
    logic                  w_accept, w_is_shift, w_load, w_step;
    logic                  w_imm_valid, w_last;
    logic [DATA_WIDTH-1:0] w_imm_result, w_step_val;

    assign ready_o    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && ready_i);
    assign w_accept   = valid_i && ready_o;
    assign w_is_shift = is_shift_op(ALU_Operation_i);
    assign w_load     = w_accept && w_is_shift;
    assign w_step     = (r_state == ST_SHIFT);

    alu_iter_shifter #(
        .DATA_WIDTH(DATA_WIDTH),
        .SHAMT_W   (SHAMT_W)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_left      (ALU_Operation_i == ALU_SLL),
        .i_a         (A_i),
        .i_shamt     (B_i[SHAMT_W-1:0]),
        .o_imm_valid (w_imm_valid),
        .o_imm_result(w_imm_result),
        .o_last      (w_last),
        .o_step_val  (w_step_val)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_res_en    = 1'b0;
        w_res_nxt   = r_result;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_is_shift && !w_imm_valid) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_res_en    = 1'b1;
                        w_res_nxt   = w_is_shift ? w_imm_result
                                                 : alu_compute(ALU_Operation_i, A_i, B_i);
                    end
                end else if ((r_state == ST_DONE) && ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_res_en    = 1'b1;
                    w_res_nxt   = w_step_val;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_res_en) begin
                r_result <= w_res_nxt;
                r_zero   <= (w_res_nxt == '0);
            end
        end
    end

    assign valid_o      = (r_state == ST_DONE);
    assign busy_o       = (r_state == ST_SHIFT);
    assign ALU_Result_o = r_result;
    assign Zero_o       = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (either ALU_FAST_SHIFT_EN build).
module tb_alu_exec_unit;

`ifdef ALU_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, ready_o, valid_o, ready_i, Zero_o, busy_o;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i, B_i, ALU_Result_o;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .ALU_Operation_i(ALU_Operation_i),
        .A_i            (A_i),
        .B_i            (B_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .ALU_Result_o   (ALU_Result_o),
        .Zero_o         (Zero_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, wait for valid_o, check latency, busy cycles and result.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_lat, input int exp_busy);
        int lat;
        int busy_n;
        ALU_Operation_i = op;
        A_i     = a;
        B_i     = b;
        valid_i = 1'b1;
        ready_i = 1'b1;
        chk({tag, "_rdy"}, {31'b0, ready_o}, 32'd1);
        tick();
        valid_i = 1'b0;
        A_i     = 32'hDEAD_BEEF;
        B_i     = 32'hDEAD_BEEF;
        lat     = 1;
        busy_n  = 0;
        while (!valid_o && lat < 200) begin
            if (busy_o) busy_n++;
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, busy_n, exp_busy);
        chk({tag, "_res"}, ALU_Result_o, exp);
        chk({tag, "_zero"}, {31'b0, Zero_o}, {31'b0, exp == 32'd0});
        tick();
        chk({tag, "_idle"}, {31'b0, valid_o}, 32'd0);
    endtask

    initial begin
        int stale;
        reset = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        ALU_Operation_i = 4'b0000;
        A_i = '0;
        B_i = '0;
        #2;
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_res", ALU_Result_o, 32'd0);
        chk("rst_zero", {31'b0, Zero_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        do_op("add", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        do_op("sub", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0);
        do_op("and", 4'b0010, 32'h0000_FF00, 32'h0000_0F0F, 32'h0000_0F00, 1, 0);
        do_op("sll31", 4'b0110, 32'h1, 32'd31, 32'h8000_0000, FAST ? 1 : 32, FAST ? 0 : 31);
        do_op("srl4", 4'b0111, 32'h8000_0000, 32'h24, 32'h0800_0000, FAST ? 1 : 5, FAST ? 0 : 4);
        do_op("sll3", 4'b0110, 32'd3, 32'd4, 32'h30, FAST ? 1 : 5, FAST ? 0 : 4);
        do_op("sll0", 4'b0110, 32'h1234, 32'h20, 32'h1234, 1, 0);
        do_op("undef", 4'b1111, 32'd5, 32'd6, 32'd0, 1, 0);

        // Back-to-back XOR then OR
        ALU_Operation_i = 4'b0100;
        A_i = 32'h0000_F0F0;
        B_i = 32'h0000_0FF0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        chk("b2b_xor_vld", {31'b0, valid_o}, 32'd1);
        chk("b2b_xor_res", ALU_Result_o, 32'h0000_FF00);
        chk("b2b_rdy", {31'b0, ready_o}, 32'd1);
        ALU_Operation_i = 4'b0011;
        tick();
        chk("b2b_or_vld", {31'b0, valid_o}, 32'd1);
        chk("b2b_or_res", ALU_Result_o, 32'h0000_FFF0);
        valid_i = 1'b0;
        tick();
        chk("b2b_idle", {31'b0, valid_o}, 32'd0);

        // Backpressure with LUI held in DONE
        ALU_Operation_i = 4'b1001;
        A_i = 32'd0;
        B_i = 32'h1234_5000;
        valid_i = 1'b1;
        ready_i = 1'b0;
        tick();
        ALU_Operation_i = 4'b0000;
        A_i = 32'd1;
        B_i = 32'd1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_res", ALU_Result_o, 32'h1234_5000);
            chk("bp_vld", {31'b0, valid_o}, 32'd1);
            chk("bp_rdy", {31'b0, ready_o}, 32'd0);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        chk("bp_rel_rdy", {31'b0, ready_o}, 32'd1);
        tick();
        chk("bp_rel_vld", {31'b0, valid_o}, 32'd0);
        chk("bp_res_kept", ALU_Result_o, 32'h1234_5000);

        // Reset in the middle of a long shift
        ALU_Operation_i = 4'b0110;
        A_i = 32'h1;
        B_i = 32'd20;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        if (!FAST) chk("mid_busy", {31'b0, busy_o}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_vld", {31'b0, valid_o}, 32'd0);
        chk("mid_rst_res", ALU_Result_o, 32'd0);
        chk("mid_rst_zero", {31'b0, Zero_o}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_rdy", {31'b0, ready_o}, 32'd1);
        chk("post_rst_vld", {31'b0, valid_o}, 32'd0);
        stale = 0;
        for (int i = 0; i < 25; i++) begin
            if (valid_o || busy_o) stale++;
            tick();
        end
        chk("no_stale", stale, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
